branch_predictor: RTL
=====================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline, replacing fixed "predict not-taken, resolve in D" fetch. It holds a direct-mapped branch target buffer (BTB) plus a table of saturating direction counters. It predicts next-PC combinationally in F, carries the prediction into D, and takes resolution from the D-stage branch/jump comparator to train itself and raise a mispredict redirect.

## Interface
- `DEPTH`, 64: BTB and counter-table entries; power of 2, ≥2; `IDX_W = log2(DEPTH)`.
- `TAG_W`, 8: tag bits stored per entry, taken from `pc[IDX_W+TAG_W+1 : IDX_W+2]`.
- `CTR_W`, 2: direction counter width, ≥1.
- `HIST_W`, 6: global history length, ≤ `IDX_W`; used only under `BP_GSHARE_EN`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `pc_f`, in, 32: PC of the instruction in F.
- `pred_taken_f`, out, 1: predicted taken; selects `pred_target_f` in the PC mux.
- `pred_target_f`, out, 32: predicted target.
- `stall_d`, in, 1: D-stage register hold; same as the hazard unit's StallD.
- `flush_d`, in, 1: clears the D-stage prediction register.
- `pred_taken_d`, out, 1: registered prediction for the instruction in D.
- `pred_target_d`, out, 32: registered predicted target for the instruction in D.
- `upd_valid`, in, 1: the D instruction is a resolved branch or jump.
- `upd_pc`, in, 32: PC of the D instruction (PCPlus4D − 4).
- `upd_taken`, in, 1: actual outcome.
- `upd_target`, in, 32: actual taken target.
- `mispredict_d`, out, 1: redirect F, flush the F→D register.
- `redirect_pc_d`, out, 32: correct next PC, `upd_taken ? upd_target : upd_pc+4`.

## Operation
- **Index and tag:** `idx = pc[IDX_W+1:2]`; `tag` as defined above. BTB entry = {valid, tag, target[31:2]}. Counter table index `cidx` = `idx`.
- **Lookup (F):** hit = `valid[idx] & tag match`.
  - `pred_taken_f = hit & ctr[cidx][CTR_W-1]`.
  - `pred_target_f = {target[idx], 2'b00}`. When `pred_taken_f=0`, `pred_target_f` is don't-care but is driven with the stored value.
- **D register:** loads {pred_taken_f, pred_target_f, cidx} each edge unless `stall_d`. `flush_d` has priority over `stall_d` and loads zero.
- **Update:** performed when `upd_valid & ~stall_d`, so each D instruction updates exactly once.
  - Counter at the registered `cidx_d` saturates up on taken, down on not-taken. It never wraps: max `2^CTR_W−1`, min 0.
  - On taken, the BTB entry at `idx(upd_pc)` is written {1, tag, upd_target[31:2]}. This covers allocation, overwriting a conflicting tag, and target change.
  - On not-taken, the BTB is unchanged; no allocation on a miss.
- **Mispredict:**
  - `mispredict_d = upd_valid & ~stall_d & ((upd_taken != pred_taken_d) | (upd_taken & upd_target != pred_target_d))`.
  - Purely combinational from D-stage state. It is 0 whenever `upd_valid=0`.
- **Reset values:**
  - All valid bits = 0.
  - Counters = `2^(CTR_W-1)−1` (weakly not-taken).
  - D register = 0.
  - History = 0.
  - Hence `pred_taken_f = pred_taken_d = mispredict_d = 0` and `pred_target_d = 0`.
- **Reset mid-operation:** all state clears immediately; no partial write survives.

## Timing
- `pred_*_f`: combinational from `pc_f` in the same cycle.
- `pred_*_d`: 1-cycle latency after F.
- `mispredict_d` and `redirect_pc_d`: same cycle as `upd_*`. Table writes land at the closing edge.
- **Same-index conflict:** a lookup and update to the same index in one cycle returns the pre-update contents; there is no bypass. The next cycle sees the new contents.
- **Tag aliasing:** a different PC with the same index and tag is treated as a hit. This is accepted behaviour.

## Configuration
- `BP_GSHARE_EN` defined:
  - An `HIST_W`-bit global history register is added.
  - `cidx = idx ^ {{(IDX_W-HIST_W){1'b0}}, ghr}`.
  - On each update, `ghr <= {ghr[HIST_W-2:0], upd_taken}`. Training is non-speculative.
  - Update uses the registered `cidx_d`, not a recomputed index.
- `BP_GSHARE_EN` undefined: `cidx = idx`, and no history register is present (bimodal).

## Structure
- **Shared package `bp_pkg`:**
  - Counter reset constant.
  - `IDX_W` and tag-slice helper functions.
  - BTB entry struct {valid, tag, target}.
- **Sub-module `bp_sat_counter_table`:** DEPTH × CTR_W array with one combinational read port, one synchronous saturating write port, and async reset.
- The BTB array, D register and mispredict logic stay in the top of the block.

## Test plan
1. **Post-reset lookup:** reset, any `pc_f` → `pred_taken_f=0`. Branch at 0x0040_0010 resolves taken to 0x0040_0100 → `mispredict_d=1`, `redirect_pc_d=0x0040_0100`.
2. **Training:** same branch resolved taken twice (CTR_W=2: count 1→2→3). The next lookup of 0x0040_0010 → `pred_taken_f=1`, `pred_target_f=0x0040_0100`, `mispredict_d=0` at resolution.
3. **Saturation and hysteresis:** from count 3, one not-taken → count 2, still predicts taken, `mispredict_d=1`, `redirect_pc_d=0x0040_0014`. Four more not-taken → count floors at 0, no wrap.
4. **Aliasing (DEPTH=64):** PC 0x0040_0010 vs 0x0040_1010 share the index with different tags → the second PC misses. A taken resolution overwrites the entry, and the first PC now misses.
5. **Stall and flush:** `stall_d=1` with `upd_valid=1` for 3 cycles → no counter or BTB change and `mispredict_d=0`. `flush_d` together with `stall_d` → D register zeroed.
6. **Reset mid-run:** `reset` pulsed between edges after training → valid bits and counters cleared at once, and `pred_taken_f=0` within the same cycle.
7. **Gshare (`BP_GSHARE_EN`, HIST_W=2):** an alternating T/N branch trains to zero mispredicts after warm-up.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: BTB entry layout,
// index/tag extraction and the counter reset value.
package bp_pkg;

  localparam int BP_FIELD_W = 30;

  typedef struct packed {
    logic                  valid;
    logic [BP_FIELD_W-1:0] tag;
    logic [BP_FIELD_W-1:0] target;
  } btbEntry_t;

  function automatic int bpIdxW(input int depth);
    return $clog2(depth);
  endfunction

  function automatic logic [31:0] bpIdx(input logic [31:0] pc, input int idxW);
    logic [31:0] mask;
    mask = (32'd1 << idxW) - 32'd1;
    return (pc >> 2) & mask;
  endfunction

  // Tag is returned zero-extended so entries compare on the full field.
  function automatic logic [BP_FIELD_W-1:0] bpTag(input logic [31:0] pc, input int idxW,
                                                  input int tagW);
    logic [31:0] mask;
    mask = (32'd1 << tagW) - 32'd1;
    return BP_FIELD_W'((pc >> (idxW + 2)) & mask);
  endfunction

  function automatic logic [31:0] bpCtrReset(input int ctrW);
    return (32'd1 << (ctrW - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// DEPTH x CTR_W saturating direction counters: one combinational read of the
// predict bit, one synchronous saturating write, async reset to weakly not-taken.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CTR_W = 2,
  parameter int IDX_W = bpIdxW(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rdIdx,
  output logic             rdTaken,
  input  logic             wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic             wrTaken
);

  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(bpCtrReset(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

  logic [CTR_W-1:0] ctr_r [DEPTH];
  logic [CTR_W-1:0] curCtr_s;
  logic [CTR_W-1:0] nextCtr_s;

  assign rdTaken  = ctr_r[rdIdx][CTR_W-1];
  assign curCtr_s = ctr_r[wrIdx];

  // Saturating step: clamps at both ends instead of wrapping.
  always_comb begin
    nextCtr_s = curCtr_s;
    if (wrTaken) begin
      if (curCtr_s != CTR_MAX) begin
        nextCtr_s = curCtr_s + CTR_W'(1);
      end else begin
        nextCtr_s = curCtr_s;
      end
    end else begin
      if (curCtr_s != CTR_MIN) begin
        nextCtr_s = curCtr_s - CTR_W'(1);
      end else begin
        nextCtr_s = curCtr_s;
      end
    end
  end

  // Counter storage with async clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_r[i] <= CTR_RST;
      end
    end else if (wrEn) begin
      ctr_r[wrIdx] <= nextCtr_s;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus saturating direction counters,
// F-stage lookup, D-stage prediction register and mispredict redirect.
// Define BP_GSHARE_EN to xor global history into the counter index (gshare).
module branch_predictor
  import bp_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic        pred_taken_d,
  output logic [31:0] pred_target_d,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        mispredict_d,
  output logic [31:0] redirect_pc_d
);

  localparam int IDX_W = bpIdxW(DEPTH);

  btbEntry_t               btb_r [DEPTH];
  logic [IDX_W-1:0]        idxF_s;
  logic [IDX_W-1:0]        idxU_s;
  logic [IDX_W-1:0]        cidxF_s;
  logic [IDX_W-1:0]        cidxD_r;
  logic [BP_FIELD_W-1:0]   tagF_s;
  logic [BP_FIELD_W-1:0]   tagU_s;
  logic                    btbHitF_s;
  logic                    ctrTakenF_s;
  logic                    updEn_s;
  logic                    predTakenD_r;
  logic [31:0]             predTargetD_r;

  assign idxF_s  = IDX_W'(bpIdx(pc_f, IDX_W));
  assign idxU_s  = IDX_W'(bpIdx(upd_pc, IDX_W));
  assign tagF_s  = bpTag(pc_f, IDX_W, TAG_W);
  assign tagU_s  = bpTag(upd_pc, IDX_W, TAG_W);
  assign updEn_s = upd_valid & ~stall_d;

`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr_r;

  assign cidxF_s = idxF_s ^ IDX_W'(ghr_r);

  // Non-speculative history: shifted only by resolved branches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_r <= {HIST_W{1'b0}};
    end else if (updEn_s) begin
      ghr_r <= {ghr_r[HIST_W-2:0], upd_taken};
    end
  end
`else
  assign cidxF_s = idxF_s;
`endif

  bp_sat_counter_table #(
    .DEPTH (DEPTH),
    .CTR_W (CTR_W),
    .IDX_W (IDX_W)
  ) uCtrTable (
    .clk     (clk),
    .reset   (reset),
    .rdIdx   (cidxF_s),
    .rdTaken (ctrTakenF_s),
    .wrEn    (updEn_s),
    .wrIdx   (cidxD_r),
    .wrTaken (upd_taken)
  );

  // No bypass: a same-cycle update is visible only after the edge.
  assign btbHitF_s     = btb_r[idxF_s].valid & (btb_r[idxF_s].tag == tagF_s);
  assign pred_taken_f  = btbHitF_s & ctrTakenF_s;
  assign pred_target_f = {btb_r[idxF_s].target, 2'b00};

  // BTB: allocate/overwrite only on taken resolutions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        btb_r[i] <= '{valid: 1'b0, tag: {BP_FIELD_W{1'b0}}, target: {BP_FIELD_W{1'b0}}};
      end
    end else if (updEn_s & upd_taken) begin
      btb_r[idxU_s] <= '{valid: 1'b1, tag: tagU_s, target: upd_target[31:2]};
    end
  end

  // D-stage prediction register; flush wins over stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      predTakenD_r  <= 1'b0;
      predTargetD_r <= 32'd0;
      cidxD_r       <= {IDX_W{1'b0}};
    end else if (flush_d) begin
      predTakenD_r  <= 1'b0;
      predTargetD_r <= 32'd0;
      cidxD_r       <= {IDX_W{1'b0}};
    end else if (~stall_d) begin
      predTakenD_r  <= pred_taken_f;
      predTargetD_r <= pred_target_f;
      cidxD_r       <= cidxF_s;
    end
  end

  assign pred_taken_d  = predTakenD_r;
  assign pred_target_d = predTargetD_r;

  assign mispredict_d  = updEn_s &
                         ((upd_taken != predTakenD_r) |
                          (upd_taken & (upd_target != predTargetD_r)));
  assign redirect_pc_d = upd_taken ? upd_target : (upd_pc + 32'd4);

endmodule
